// File: rtl/jump_handle.sv
// Hack-CPU jump decision: combinational PC load/increment from jump field and ALU flags,
// plus a sticky flag-consistency check. Optional jump statistics under `JMP_STATS_EN.
module jump_handle #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             opcode,
   input  logic             j1,
   input  logic             j2,
   input  logic             j3,
   input  logic             zr,
   input  logic             ng,
   output logic             out_load,
   output logic             out_inc,
   output logic             flag_err,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   logic pos;
   logic cond;
   logic take;

   assign pos  = ~zr & ~ng;
   assign cond = (j1 & ng) | (j2 & zr) | (j3 & pos);
   assign take = opcode & cond;

   // Reset overrides both controls so the PC holds while rst is high.
   always_comb begin
      out_load = ~rst & take;
      out_inc  = ~rst & ~take;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_err <= 1'b0;
      end else if (zr & ng) begin
         flag_err <= 1'b1;
      end
   end

`ifdef JMP_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Saturating counters: hold at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         taken_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (out_load && (taken_cnt != CNT_MAX)) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
         end
         if (opcode && (instr_cnt != CNT_MAX)) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign taken_cnt = '0;
   assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_jump_handle.sv
// Self-checking bench for jump_handle: mnemonic-level reference model, directed
// literal checks, a full sweep and randomized stimulus. Honours `JMP_STATS_EN.
module tb_jump_handle;

   localparam int TB_CNT_W = 2;
   localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                opcode = 1'b0;
   logic                j1 = 1'b0, j2 = 1'b0, j3 = 1'b0;
   logic                zr = 1'b0, ng = 1'b0;
   logic                out_load, out_inc, flag_err;
   logic [TB_CNT_W-1:0] taken_cnt, instr_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit m_flag_err = 1'b0;
   int m_taken    = 0;
   int m_instr    = 0;
   bit compare_en = 1'b0;

   jump_handle #(.CNT_W(TB_CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .j1        (j1),
      .j2        (j2),
      .j3        (j3),
      .zr        (zr),
      .ng        (ng),
      .out_load  (out_load),
      .out_inc   (out_inc),
      .flag_err  (flag_err),
      .taken_cnt (taken_cnt),
      .instr_cnt (instr_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Jump decision from the mnemonic meaning: j1 = "less", j2 = "equal", j3 = "greater".
   function automatic bit model_take(bit op, bit [2:0] j, bit z, bit n);
      bit lt, eq, gt;
      lt = n;
      eq = z;
      gt = !z && !n;
      if (!op) return 1'b0;
      return (j[2] && lt) || (j[1] && eq) || (j[0] && gt);
   endfunction

   function automatic int sat_inc(int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   // Model register updates
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_flag_err = 1'b0;
         m_taken    = 0;
         m_instr    = 0;
      end else begin
         if (zr && ng) m_flag_err = 1'b1;
         if (model_take(opcode, {j1, j2, j3}, zr, ng)) m_taken = sat_inc(m_taken);
         if (opcode) m_instr = sat_inc(m_instr);
      end
   end

   // Per-cycle comparison, sampled on the falling edge
   always @(negedge clk) begin
      if (compare_en) begin
         bit tk;
         tk = model_take(opcode, {j1, j2, j3}, zr, ng);
         check("out_load", 32'(out_load), 32'(!rst && tk));
         check("out_inc",  32'(out_inc),  32'(!rst && !tk));
         check("flag_err", 32'(flag_err), 32'(m_flag_err));
`ifdef JMP_STATS_EN
         check("taken_cnt", 32'(taken_cnt), 32'(m_taken));
         check("instr_cnt", 32'(instr_cnt), 32'(m_instr));
`else
         check("taken_cnt", 32'(taken_cnt), 32'd0);
         check("instr_cnt", 32'(instr_cnt), 32'd0);
`endif
      end
   end

   // Apply a vector just after a rising edge; outputs settle before the falling edge.
   task automatic apply(input bit op, input bit [2:0] j, input bit z, input bit n);
      @(posedge clk);
      #1;
      opcode = op;
      {j1, j2, j3} = j;
      zr = z;
      ng = n;
      @(negedge clk);
      #1;
   endtask

   task automatic expect_pc(input string name, input bit ld, input bit inc);
      check({name, "_load"}, 32'(out_load), 32'(ld));
      check({name, "_inc"},  32'(out_inc),  32'(inc));
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #2;
      expect_pc("reset", 1'b0, 1'b0);
      check("reset_flag_err", 32'(flag_err), 32'd0);
      check("reset_taken", 32'(taken_cnt), 32'd0);
      check("reset_instr", 32'(instr_cnt), 32'd0);

      @(posedge clk);
      #1;
      rst = 1'b0;
      compare_en = 1'b1;

      // Hand-computed literals that also pin the model
      apply(1'b0, 3'b001, 1'b0, 1'b0); expect_pc("a_instr_jgt", 1'b0, 1'b1);
      apply(1'b0, 3'b111, 1'b1, 1'b0); expect_pc("a_instr_jmp", 1'b0, 1'b1);
      apply(1'b1, 3'b001, 1'b0, 1'b0); expect_pc("jgt_pos",     1'b1, 1'b0);
      apply(1'b1, 3'b010, 1'b1, 1'b0); expect_pc("jeq_zero",    1'b1, 1'b0);
      apply(1'b1, 3'b011, 1'b1, 1'b0); expect_pc("jge_zero",    1'b1, 1'b0);
      apply(1'b1, 3'b011, 1'b0, 1'b0); expect_pc("jge_pos",     1'b1, 1'b0);
      apply(1'b1, 3'b100, 1'b0, 1'b1); expect_pc("jlt_neg",     1'b1, 1'b0);
      apply(1'b1, 3'b101, 1'b1, 1'b0); expect_pc("jne_zero",    1'b0, 1'b1);
      apply(1'b1, 3'b000, 1'b0, 1'b1); expect_pc("null_neg",    1'b0, 1'b1);
      apply(1'b1, 3'b110, 1'b0, 1'b0); expect_pc("jle_pos",     1'b0, 1'b1);

      // Full sweep of jump field against legal flag combinations
      for (int j = 0; j < 8; j++) begin
         apply(1'b1, 3'(j), 1'b0, 1'b0);
         apply(1'b1, 3'(j), 1'b1, 1'b0);
         apply(1'b1, 3'(j), 1'b0, 1'b1);
      end

      // Asynchronous reset mid-cycle with an unconditional jump
      apply(1'b1, 3'b111, 1'b0, 1'b0);
      expect_pc("pre_async_rst", 1'b1, 1'b0);
      #1 rst = 1'b1;
      #1 expect_pc("async_rst", 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 expect_pc("rst_release", 1'b1, 1'b0);

      // Illegal flag pair for one edge makes flag_err sticky
      apply(1'b1, 3'b101, 1'b1, 1'b1);
      expect_pc("zr_ng_both", 1'b1, 1'b0);
      apply(1'b1, 3'b010, 1'b1, 1'b0);
      check("flag_err_set", 32'(flag_err), 32'd1);
      apply(1'b0, 3'b000, 1'b0, 1'b0);
      apply(1'b0, 3'b000, 1'b0, 1'b0);
      check("flag_err_sticky", 32'(flag_err), 32'd1);
      rst = 1'b1;
      #1 check("flag_err_rst", 32'(flag_err), 32'd0);

      // Statistics saturation: five unconditional jumps into a 2-bit counter
      @(posedge clk);
      #1;
      rst = 1'b0;
      opcode = 1'b1;
      {j1, j2, j3} = 3'b111;
      zr = 1'b0;
      ng = 1'b0;
      repeat (5) @(posedge clk);
      #1;
`ifdef JMP_STATS_EN
      check("taken_sat", 32'(taken_cnt), 32'd3);
      check("instr_sat", 32'(instr_cnt), 32'd3);
`else
      check("taken_off", 32'(taken_cnt), 32'd0);
      check("instr_off", 32'(instr_cnt), 32'd0);
`endif
      rst = 1'b1;
      #1;
      check("taken_rst", 32'(taken_cnt), 32'd0);
      check("instr_rst", 32'(instr_cnt), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Randomized traffic; illegal flag pairs appear rarely
      for (int i = 0; i < 400; i++) begin
         bit z, n;
         z = 1'($urandom_range(0, 1));
         n = (z && ($urandom_range(0, 19) != 0)) ? 1'b0 : 1'($urandom_range(0, 1));
         apply(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), z, n);
         if (i == 200) begin
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
      end

      compare_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
